// File: rtl/fx_mode_sequencer_if.sv
// Sync and mode-control bundle between the host/timing side and fx_mode_sequencer.
// The host drives sync inputs and mode requests; the sequencer returns the mode and delayed sync.
interface fx_mode_sequencer_if;
    logic       vsync_in;
    logic       hsync_in;
    logic       de_in;
    logic [3:0] mode_req;
    logic       mode_req_valid;
    logic       auto_en;
    logic [7:0] auto_frames;
    logic [3:0] mode_out;
    logic       mode_pending;
    logic       mode_err;
    logic       frame_start;
    logic       vsync_out;
    logic       hsync_out;
    logic       de_out;

    modport master (
        output vsync_in, hsync_in, de_in, mode_req, mode_req_valid, auto_en, auto_frames,
        input  mode_out, mode_pending, mode_err, frame_start, vsync_out, hsync_out, de_out
    );

    modport slave (
        input  vsync_in, hsync_in, de_in, mode_req, mode_req_valid, auto_en, auto_frames,
        output mode_out, mode_pending, mode_err, frame_start, vsync_out, hsync_out, de_out
    );
endinterface

// File: rtl/fx_mode_sequencer.sv
// Effect-mode sequencer: applies host mode requests (or auto-cycle steps) only at frame
// boundaries and delays hsync/vsync/de to line up with the effect-stage pixel pipeline.
module fx_mode_sequencer #(
    parameter int unsigned SYNC_DELAY = 1,
    parameter bit          VS_POL     = 1'b1,
    parameter logic [3:0]  RESET_MODE = 4'b0000
) (
    input logic                pxclk,
    input logic                rst_n,
    fx_mode_sequencer_if.slave bus
);
    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] pend_mode, pend_mode_nxt;
    logic [3:0] mode_q, mode_nxt;
    logic [7:0] frame_cnt, frame_cnt_nxt;
    logic       vs_act, vs_q, frame_start_q, mode_err_q;
    logic       req_ok, auto_on;
    logic [2:0] sync_sr [SYNC_DELAY];

    function automatic logic is_valid(input logic [3:0] m);
        return (m <= 4'd5) || ((m >= 4'd7) && (m <= 4'd10));
    endfunction

    // Auto-cycle order skips the invalid code 6 and wraps 10 -> 0.
    function automatic logic [3:0] next_mode(input logic [3:0] m);
        logic [3:0] n;
        case (m)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: n = m + 4'd1;
            4'd5:                         n = 4'd7;
            4'd7, 4'd8, 4'd9:             n = m + 4'd1;
            default:                      n = 4'd0;
        endcase
        return n;
    endfunction

    assign vs_act  = (bus.vsync_in == VS_POL);
    assign req_ok  = bus.mode_req_valid && is_valid(bus.mode_req);
    assign auto_on = bus.auto_en && (bus.auto_frames != '0);

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend_mode     <= RESET_MODE;
            mode_q        <= RESET_MODE;
            frame_cnt     <= '0;
            vs_q          <= 1'b0;
            frame_start_q <= 1'b0;
            mode_err_q    <= 1'b0;
        end else begin
            state         <= state_nxt;
            pend_mode     <= pend_mode_nxt;
            mode_q        <= mode_nxt;
            frame_cnt     <= frame_cnt_nxt;
            vs_q          <= vs_act;
            frame_start_q <= vs_act && !vs_q;
            mode_err_q    <= bus.mode_req_valid && !is_valid(bus.mode_req);
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_mode_nxt = pend_mode;
        mode_nxt      = mode_q;
        frame_cnt_nxt = auto_on ? frame_cnt : '0;
        if (frame_start_q) begin
            // Boundary priority: same-cycle request, then held request, then auto step.
            if (req_ok) begin
                mode_nxt      = bus.mode_req;
                state_nxt     = IDLE;
                frame_cnt_nxt = '0;
            end else if (state == PEND) begin
                mode_nxt      = pend_mode;
                state_nxt     = IDLE;
                frame_cnt_nxt = '0;
            end else if (auto_on) begin
                // >= so that shrinking auto_frames below the count still steps next frame.
                if (frame_cnt >= (bus.auto_frames - 8'd1)) begin
                    mode_nxt      = next_mode(mode_q);
                    frame_cnt_nxt = '0;
                end else begin
                    frame_cnt_nxt = frame_cnt + 8'd1;
                end
            end
        end else if (req_ok) begin
            state_nxt     = PEND;
            pend_mode_nxt = bus.mode_req;
        end
    end

    always_ff @(posedge pxclk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_DELAY; i++) begin
                sync_sr[i] <= '0;
            end
        end else begin
            sync_sr[0] <= {bus.vsync_in, bus.hsync_in, bus.de_in};
            for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
                sync_sr[i] <= sync_sr[i-1];
            end
        end
    end

    assign bus.mode_out     = mode_q;
    assign bus.mode_pending = (state == PEND);
    assign bus.mode_err     = mode_err_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.vsync_out    = sync_sr[SYNC_DELAY-1][2];
    assign bus.hsync_out    = sync_sr[SYNC_DELAY-1][1];
    assign bus.de_out       = sync_sr[SYNC_DELAY-1][0];
endmodule
